universal_shift_register: RTL and testbench

Parametrised universal shift register, the successor to the team's fixed 4-bit serial-in shift register. Supports hold, shift right, shift left and parallel load, with an optional rotate mode. Adds an autonomous burst mode that performs a programmed number of shifts, reporting progress with busy and done. Used as the general-purpose shift/rotate datapath element in the homework designs.

---
 rtl/universal_shift_register.sv | 139 +++++++++++++
 tb/tb_universal_shift_register.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register
// Description : Parametrised hold / shift / rotate / load register with an
//               autonomous multi-shift burst engine (busy / done handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             shift_control,
    input  logic             SI_R,
    input  logic             SI_L,
    input  logic [WIDTH-1:0] D,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] RA,
    output logic             SO_R,
    output logic             SO_L,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_RIGHT = 2'b01;
    localparam logic [1:0] c_MODE_LEFT  = 2'b10;
    localparam logic [1:0] c_MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] w_ra_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_dir_left;
    logic             w_dir_left_next;
    logic             r_rot;
    logic             w_rot_next;

    // Single-step shift results; the burst path reuses them with latched controls.
    function automatic logic [WIDTH-1:0] f_shift_right(
        input logic [WIDTH-1:0] val,
        input logic             rot,
        input logic             si
    );
        f_shift_right = {(rot ? val[0] : si), val[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] f_shift_left(
        input logic [WIDTH-1:0] val,
        input logic             rot,
        input logic             si
    );
        f_shift_left = {val[WIDTH-2:0], (rot ? val[WIDTH-1] : si)};
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_ra       <= '0;
            r_cnt      <= '0;
            r_dir_left <= 1'b0;
            r_rot      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ra       <= w_ra_next;
            r_cnt      <= w_cnt_next;
            r_dir_left <= w_dir_left_next;
            r_rot      <= w_rot_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ra_next       = r_ra;
        w_cnt_next      = r_cnt;
        w_dir_left_next = r_dir_left;
        w_rot_next      = r_rot;

        case (r_state)
            ST_IDLE: begin
                // A burst request only wins when the mode names a shift direction.
                if (burst_start && (mode == c_MODE_RIGHT || mode == c_MODE_LEFT)) begin
                    w_dir_left_next = (mode == c_MODE_LEFT);
                    w_rot_next      = rotate;
                    w_cnt_next      = burst_len;
                    w_state_next    = (burst_len != c_CNT_ZERO) ? ST_BURST : ST_DONE;
                end else if (shift_control) begin
                    case (mode)
                        c_MODE_HOLD:  w_ra_next = r_ra;
                        c_MODE_RIGHT: w_ra_next = f_shift_right(r_ra, rotate, SI_R);
                        c_MODE_LEFT:  w_ra_next = f_shift_left(r_ra, rotate, SI_L);
                        c_MODE_LOAD:  w_ra_next = D;
                        default:      w_ra_next = r_ra;
                    endcase
                end
            end

            ST_BURST: begin
                w_ra_next  = r_dir_left ? f_shift_left(r_ra, r_rot, SI_L)
                                        : f_shift_right(r_ra, r_rot, SI_R);
                w_cnt_next = r_cnt - c_CNT_ONE;
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign RA   = r_ra;
    assign SO_R = r_ra[0];
    assign SO_L = r_ra[WIDTH-1];
    assign busy = (r_state == ST_BURST);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Directed self-checking bench for universal_shift_register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             clear;
    logic [1:0]       mode;
    logic             rotate;
    logic             shift_control;
    logic             SI_R;
    logic             SI_L;
    logic [WIDTH-1:0] D;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] RA;
    logic             SO_R;
    logic             SO_L;
    logic             busy;
    logic             done;

    int checks;
    int failures;

    universal_shift_register #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .mode         (mode),
        .rotate       (rotate),
        .shift_control(shift_control),
        .SI_R         (SI_R),
        .SI_L         (SI_L),
        .D            (D),
        .burst_start  (burst_start),
        .burst_len    (burst_len),
        .RA           (RA),
        .SO_R         (SO_R),
        .SO_L         (SO_L),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        burst_start   = 1'b0;
        mode          = 2'b11;
        shift_control = 1'b1;
        D             = val;
        tick();
        shift_control = 1'b0;
        mode          = 2'b00;
    endtask

    task automatic test_reset();
        clear = 1'b1; mode = 2'b10; rotate = 1'b1; shift_control = 1'b1;
        SI_R = 1'b1; SI_L = 1'b1; D = 8'hFF; burst_start = 1'b1; burst_len = 4'd7;
        tick();
        tick();
        checks++; if (RA !== 8'h00) begin failures++; $display("FAIL reset_ra got=%h exp=00", RA); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", busy, done); end
        checks++; if (SO_R !== 1'b0 || SO_L !== 1'b0) begin failures++; $display("FAIL reset_so so_r=%b so_l=%b exp=0/0", SO_R, SO_L); end
        clear = 1'b0; mode = 2'b00; rotate = 1'b0; shift_control = 1'b0;
        SI_R = 1'b0; SI_L = 1'b0; D = '0; burst_start = 1'b0; burst_len = '0;
    endtask

    task automatic test_load_hold();
        load(8'hA5);
        checks++; if (RA !== 8'hA5) begin failures++; $display("FAIL load got=%h exp=A5", RA); end
        mode = 2'b00; shift_control = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (RA !== 8'hA5) begin failures++; $display("FAIL hold got=%h exp=A5", RA); end
        mode = 2'b01; shift_control = 1'b0; SI_R = 1'b1;
        tick();
        checks++; if (RA !== 8'hA5) begin failures++; $display("FAIL no_enable got=%h exp=A5", RA); end
        SI_R = 1'b0;
    endtask

    task automatic test_shift();
        rotate = 1'b0;
        load(8'hA5);
        mode = 2'b01; SI_R = 1'b1; shift_control = 1'b1;
        tick();
        checks++; if (RA !== 8'hD2 || SO_R !== 1'b0) begin failures++; $display("FAIL shift_right got=%h so_r=%b exp=D2/0", RA, SO_R); end
        SI_R = 1'b0;
        load(8'hA5);
        mode = 2'b10; SI_L = 1'b0; shift_control = 1'b1;
        tick();
        checks++; if (RA !== 8'h4A || SO_L !== 1'b0) begin failures++; $display("FAIL shift_left got=%h so_l=%b exp=4A/0", RA, SO_L); end
        load(8'h7F);
        mode = 2'b10; SI_L = 1'b1; shift_control = 1'b1;
        tick();
        checks++; if (RA !== 8'hFF || SO_L !== 1'b1) begin failures++; $display("FAIL shift_left_si1 got=%h so_l=%b exp=FF/1", RA, SO_L); end
        SI_L = 1'b0;
    endtask

    task automatic test_rotate();
        rotate = 1'b1;
        load(8'h81);
        mode = 2'b10; shift_control = 1'b1; SI_L = 1'b0;
        tick();
        checks++; if (RA !== 8'h03) begin failures++; $display("FAIL rot_left got=%h exp=03", RA); end
        load(8'h01);
        mode = 2'b01; shift_control = 1'b1; SI_R = 1'b0;
        tick();
        checks++; if (RA !== 8'h80) begin failures++; $display("FAIL rot_right got=%h exp=80", RA); end
        load(8'hA5);
        mode = 2'b01; shift_control = 1'b1;
        tick();
        checks++; if (RA !== 8'hD2) begin failures++; $display("FAIL rot_right_step got=%h exp=D2", RA); end
        for (int i = 0; i < 7; i++) tick();
        checks++; if (RA !== 8'hA5) begin failures++; $display("FAIL rot_right_x8 got=%h exp=A5", RA); end
        shift_control = 1'b0; rotate = 1'b0;
    endtask

    task automatic test_burst();
        logic [WIDTH-1:0] exp_ra;
        load(8'h01);
        mode = 2'b10; rotate = 1'b1; burst_len = 4'd3; burst_start = 1'b1;
        tick();
        checks++; if (busy !== 1'b1 || done !== 1'b0 || RA !== 8'h01) begin failures++; $display("FAIL burst_accept busy=%b done=%b ra=%h exp=1/0/01", busy, done, RA); end
        // Disturb every ignored control while the burst runs.
        mode = 2'b11; D = 8'hFF; shift_control = 1'b1; rotate = 1'b0; SI_L = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_ra = 8'h02 << i;
            checks++;
            if (RA !== exp_ra || busy !== (i < 2) || done !== (i == 2)) begin
                failures++;
                $display("FAIL burst_step%0d ra=%h busy=%b done=%b exp=%h/%b/%b", i, RA, busy, done, exp_ra, (i < 2), (i == 2));
            end
        end
        mode = 2'b00; shift_control = 1'b0; burst_start = 1'b0;
        tick();
        checks++; if (RA !== 8'h08 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL burst_after ra=%h busy=%b done=%b exp=08/0/0", RA, busy, done); end
    endtask

    task automatic test_burst_serial();
        load(8'h00);
        mode = 2'b01; rotate = 1'b0; burst_len = 4'd2; burst_start = 1'b1;
        tick();
        burst_start = 1'b0; SI_R = 1'b1;
        tick();
        SI_R = 1'b0;
        tick();
        checks++; if (RA !== 8'h40 || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL burst_live_si ra=%h done=%b busy=%b exp=40/1/0", RA, done, busy); end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_abort();
        load(8'h01);
        mode = 2'b10; rotate = 1'b0; SI_L = 1'b0; burst_len = 4'd5; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        tick();
        tick();
        checks++; if (RA !== 8'h04 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre ra=%h busy=%b exp=04/1", RA, busy); end
        clear = 1'b1;
        tick();
        checks++; if (RA !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort ra=%h busy=%b done=%b exp=00/0/0", RA, busy, done); end
        clear = 1'b0; mode = 2'b00;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_no_done busy=%b done=%b exp=0/0", busy, done); end
    endtask

    task automatic test_zero_len();
        load(8'h3C);
        mode = 2'b01; rotate = 1'b0; burst_len = 4'd0; burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || RA !== 8'h3C) begin failures++; $display("FAIL zero_len done=%b busy=%b ra=%h exp=1/0/3C", done, busy, RA); end
        mode = 2'b00;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0 || RA !== 8'h3C) begin failures++; $display("FAIL zero_len_after done=%b busy=%b ra=%h exp=0/0/3C", done, busy, RA); end
    endtask

    task automatic test_back_to_back();
        load(8'h3C);
        mode = 2'b10; rotate = 1'b1; burst_len = 4'd1; burst_start = 1'b1;
        tick();
        tick();
        checks++; if (RA !== 8'h78 || done !== 1'b1) begin failures++; $display("FAIL b2b_first ra=%h done=%b exp=78/1", RA, done); end
        // Request still held: ignored in DONE, accepted once back in IDLE.
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || RA !== 8'h78) begin failures++; $display("FAIL b2b_done_ignores busy=%b done=%b ra=%h exp=0/0/78", busy, done, RA); end
        tick();
        burst_start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
        tick();
        checks++; if (RA !== 8'hF0 || done !== 1'b1) begin failures++; $display("FAIL b2b_second ra=%h done=%b exp=F0/1", RA, done); end
        mode = 2'b00;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_hold();
        test_shift();
        test_rotate();
        test_burst();
        test_burst_serial();
        test_abort();
        test_zero_len();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
